lock_key_loader: RTL
====================

Name: lock_key_loader

Overview:
- Sequential key-programming controller for the locked c432 datapath.
- Serially receives a KEY_W-bit locking key plus one even-parity bit, checks the parity, then commits the key to a held register.
- The held register drives the mux-select key bits (p1..p4) and XOR key bits (X_1..X_16) of the locked netlist.
- Repeated parity failures force a lockout that only reset clears.

Parameters:
- KEY_W, 20: total key bits; top 4 are mux keys, lower KEY_W-4 are XOR keys.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W > KEY_W.
- MAX_FAIL, 3: consecutive parity failures that trigger lockout (range 1..15).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  starts a load session; sampled only in IDLE.
- abort  in  1  cancels an in-progress session.
- key_in  in  1  serial key/parity bit.
- key_in_valid  in  1  key_in is valid this cycle.
- key_in_ready  out  1  controller accepts key_in this cycle.
- key_p  out  4  mux keys; key_p[0]=p1 .. key_p[3]=p4.
- key_x  out  KEY_W-4  XOR keys; key_x[0]=X_1 .. key_x[15]=X_16.
- key_active  out  1  a committed key is driving key_p/key_x.
- busy  out  1  state is not IDLE and not LOCKOUT.
- done  out  1  one-cycle pulse on successful commit.
- err  out  1  one-cycle pulse on parity failure.
- locked_out  out  1  lockout state reached.

Behaviour:
- Reset (synchronous, active-high, takes priority in any state):
  - state goes to IDLE.
  - Shadow register, active register, bit counter and fail counter all clear to 0.
  - All outputs are 0 from the first cycle after the reset edge.
- States: IDLE, SHIFT, PARITY, CHECK, LOCKOUT.
- IDLE:
  - key_in_ready=0.
  - load_start=1 moves to SHIFT; bit counter and shadow are cleared.
  - key_active and the active register are unaffected.
- SHIFT:
  - key_in_ready=1.
  - On a transfer (valid & ready): shadow <= {shadow[KEY_W-2:0], key_in}, counter increments. The first bit received ends up in shadow[KEY_W-1].
  - After the KEY_W-th transfer, move to PARITY.
  - valid=0 cycles stall with no state change.
- PARITY:
  - key_in_ready=1.
  - On a transfer, latch the parity bit and move to CHECK.
- CHECK (1 cycle, key_in_ready=0):
  - Pass when XOR(shadow) == parity bit. Then: active <= shadow, key_active <= 1, fail counter <= 0, done=1 in the following cycle, return to IDLE.
  - Fail: active unchanged, fail counter +1, err=1 in the following cycle.
  - On fail, if the new fail count == MAX_FAIL: go to LOCKOUT. Otherwise go to IDLE.
- Latency: parity bit accepted in cycle T; CHECK runs in T+1; new key_p/key_x, key_active, and done/err are visible in T+2.
- LOCKOUT (absorbing until rst):
  - On entry, active register is cleared and key_active=0.
  - locked_out=1, key_in_ready=0; load_start and abort are ignored.
- Key output mapping:
  - key_p = active[KEY_W-1:KEY_W-4].
  - key_x = active[KEY_W-5:0].
  - Both are registered with no combinational path from inputs.
- abort:
  - In SHIFT or PARITY: return to IDLE next cycle. Shadow is discarded; active register, key_active and fail counter are unchanged. A transfer in the same cycle is dropped.
  - In CHECK: abort has no effect; the check completes.
- Other boundaries:
  - load_start outside IDLE is ignored.
  - key_in_valid outside SHIFT/PARITY is ignored.
  - A new successful load overwrites a previously active key.
  - The fail counter saturates and is never observed above MAX_FAIL.
- Reset mid-session: discards everything, including a previously committed key.

Test Plan:
- Good load: rst, then load_start, then 20 bits of 20'hA5F3C MSB-first, then parity 0. Required:
  - key_p=4'hA (p4=1, p3=0, p2=1, p1=0), key_x=16'h5F3C.
  - key_active=1 and done pulses exactly 2 cycles after the parity bit.
- Bad parity: same key with parity 1. Required:
  - err pulse in T+2; key_p/key_x stay 0; key_active=0; state back in IDLE (busy=0).
- Lockout: 3 consecutive bad-parity sessions after a committed 20'hA5F3C. Required:
  - locked_out=1 and key_x=0, key_active=0.
  - A further load_start with a good key leaves key_in_ready=0.
  - rst then returns to IDLE with all outputs 0.
- Stalls and abort:
  - Good load with key_in_valid toggled randomly: same result as the good-load case.
  - Load aborted after 7 bits, with 20'hA5F3C already active: key_x remains 16'h5F3C, no done/err, busy=0 next cycle.
- Fail-counter reset: 2 bad loads, then a good load of 20'h00001 with parity 1, then 2 more bad loads. Required:
  - No lockout occurs.
  - key_x=16'h0001, key_p=0 after the good load.
- Reset mid-shift: rst asserted at bit 10 of a load. Required:
  - Next cycle all outputs 0 and key_in_ready=0.
  - A subsequent full good load succeeds normally.

Source files
------------

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : lock_key_loader
// Brief    : Serial key loader with even-parity check, commit register and
//            lockout after repeated parity failures (locked c432 key drive).
// Revision : 1.0 - initial release
// ============================================================================
module lock_key_loader #(
    parameter int KEY_W    = 20,
    parameter int CNT_W    = 5,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             abort,
    input  logic             key_in,
    input  logic             key_in_valid,
    output logic             key_in_ready,
    output logic [3:0]       key_p,
    output logic [KEY_W-5:0] key_x,
    output logic             key_active,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             locked_out
);

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       c_MAX_FAIL = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_PARITY  = 3'd2,
        S_CHECK   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   w_shadow_nx;
    logic [KEY_W-1:0]   r_active;
    logic [KEY_W-1:0]   w_active_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [3:0]         r_fail;
    logic [3:0]         w_fail_nx;
    logic               r_parity;
    logic               w_parity_nx;
    logic               r_key_active;
    logic               w_key_active_nx;
    logic               r_done;
    logic               w_done_nx;
    logic               r_err;
    logic               w_err_nx;
    logic               w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shadow     <= '0;
            r_active     <= '0;
            r_cnt        <= '0;
            r_fail       <= '0;
            r_parity     <= 1'b0;
            r_key_active <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shadow     <= w_shadow_nx;
            r_active     <= w_active_nx;
            r_cnt        <= w_cnt_nx;
            r_fail       <= w_fail_nx;
            r_parity     <= w_parity_nx;
            r_key_active <= w_key_active_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_shadow_nx     = r_shadow;
        w_active_nx     = r_active;
        w_cnt_nx        = r_cnt;
        w_fail_nx       = r_fail;
        w_parity_nx     = r_parity;
        w_key_active_nx = r_key_active;
        w_done_nx       = 1'b0;
        w_err_nx        = 1'b0;
        w_ready         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nx  = S_SHIFT;
                    w_cnt_nx    = '0;
                    w_shadow_nx = '0;
                end
            end
            S_SHIFT: begin
                w_ready = 1'b1;
                // Abort wins over a same-cycle transfer, dropping that bit.
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (key_in_valid) begin
                    w_shadow_nx = {r_shadow[KEY_W-2:0], key_in};
                    w_cnt_nx    = r_cnt + 1'b1;
                    if (r_cnt == c_LAST_BIT) begin
                        w_state_nx = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                w_ready = 1'b1;
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (key_in_valid) begin
                    w_parity_nx = key_in;
                    w_state_nx  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((^r_shadow) == r_parity) begin
                    w_active_nx     = r_shadow;
                    w_key_active_nx = 1'b1;
                    w_fail_nx       = '0;
                    w_done_nx       = 1'b1;
                    w_state_nx      = S_IDLE;
                end else begin
                    w_err_nx = 1'b1;
                    if (r_fail + 4'd1 >= c_MAX_FAIL) begin
                        // Lockout scrubs the committed key so nothing drives the netlist.
                        w_fail_nx       = c_MAX_FAIL;
                        w_active_nx     = '0;
                        w_key_active_nx = 1'b0;
                        w_state_nx      = S_LOCKOUT;
                    end else begin
                        w_fail_nx  = r_fail + 4'd1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                w_state_nx = S_LOCKOUT;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign key_in_ready = w_ready;
    assign key_p        = r_active[KEY_W-1:KEY_W-4];
    assign key_x        = r_active[KEY_W-5:0];
    assign key_active   = r_key_active;
    assign busy         = (r_state != S_IDLE) && (r_state != S_LOCKOUT);
    assign done         = r_done;
    assign err          = r_err;
    assign locked_out   = (r_state == S_LOCKOUT);

endmodule
`default_nettype wire
